bram_arbiter: RTL and testbench



---
 rtl/bram_arb_pkg.sv | 14 +
 rtl/bram_arbiter_if.sv | 32 +++
 rtl/bram_arbiter_rr_pick2.sv | 25 ++
 rtl/bram_arbiter.sv | 103 ++++++++++
 tb/tb_bram_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_arb_pkg.sv
// Shared constants and types for the two-requester block-RAM arbiter.
package bram_arb_pkg;

   localparam int NREQ       = 2;
   localparam int BYTE_LANES = 4;
   localparam int DATA_WIDTH = 32;

   typedef logic req_idx_t;

   function automatic logic [NREQ-1:0] idx2oh(req_idx_t i);
      return i ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// Requester and RAM-side bus bundle of the block-RAM arbiter.
interface bram_arbiter_if #(
   parameter int ADDR_WIDTH = 14
) ();
   import bram_arb_pkg::*;

   logic [NREQ-1:0]                 req_i;
   logic [NREQ-1:0][BYTE_LANES-1:0] we_i;
   logic [NREQ-1:0][ADDR_WIDTH-1:0] addr_i;
   logic [NREQ-1:0][DATA_WIDTH-1:0] wdata_i;
   logic [NREQ-1:0]                 gnt_o;
   logic [NREQ-1:0]                 rvalid_o;
   logic [DATA_WIDTH-1:0]           rdata_o;
   logic [ADDR_WIDTH-1:0]           ram_addra;
   logic [DATA_WIDTH-1:0]           ram_dina;
   logic [BYTE_LANES-1:0]           ram_wea;
   logic [ADDR_WIDTH-1:0]           ram_addrb;
   logic [DATA_WIDTH-1:0]           ram_doutb;

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, ram_doutb,
      output gnt_o, rvalid_o, rdata_o,
      output ram_addra, ram_dina, ram_wea, ram_addrb
   );

   modport master (
      output req_i, we_i, addr_i, wdata_i, ram_doutb,
      input  gnt_o, rvalid_o, rdata_o,
      input  ram_addra, ram_dina, ram_wea, ram_addrb
   );

endinterface

// File: rtl/bram_arbiter_rr_pick2.sv
// 2-way round-robin picker: the pointer requester wins a tie.
module rr_pick2
   import bram_arb_pkg::*;
(
   input  logic [NREQ-1:0] i_req,
   input  req_idx_t        i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output req_idx_t        o_idx,
   output logic            o_any,
   output req_idx_t        o_nxt_ptr
);

   always_comb begin
      o_idx = 1'b0;
      unique case (i_req)
         2'b11:   o_idx = i_ptr;
         2'b10:   o_idx = 1'b1;
         default: o_idx = 1'b0;
      endcase
      o_any     = |i_req;
      o_gnt     = o_any ? idx2oh(o_idx) : '0;
      o_nxt_ptr = o_any ? ~o_idx : i_ptr;
   end

endmodule

// File: rtl/bram_arbiter.sv
// Arbitrates two requesters onto the write and read ports of a
// simple dual-port block RAM, holding reads that hit a same-cycle write.
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 14
) (
   input  logic           HCLK,
   input  logic           HRESETn,
   bram_arbiter_if.slave  bus
);

   logic [NREQ-1:0] w_wr_req;
   logic [NREQ-1:0] w_rd_req;
   logic [NREQ-1:0] w_wr_gnt;
   logic [NREQ-1:0] w_rd_gnt;
   req_idx_t        w_wr_idx;
   req_idx_t        w_rd_idx;
   req_idx_t        w_wr_nptr;
   req_idx_t        w_rd_nptr;
   logic            w_wr_any;
   logic            w_rd_any;
   logic            w_coll;
   logic            w_wr_ok;
   logic            w_rd_ok;

   req_idx_t              r_wptr;
   req_idx_t              r_rptr;
   logic                  r_rvld;
   req_idx_t              r_ridx;
   logic [ADDR_WIDTH-1:0] r_addra;
   logic [ADDR_WIDTH-1:0] r_addrb;
   logic [DATA_WIDTH-1:0] r_dina;

   always_comb begin
      w_wr_req = '0;
      w_rd_req = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_wr_req[i] = bus.req_i[i] & (|bus.we_i[i]);
         w_rd_req[i] = bus.req_i[i] & ~(|bus.we_i[i]);
      end
   end

   rr_pick2 u_wr_pick (
      .i_req     (w_wr_req),
      .i_ptr     (r_wptr),
      .o_gnt     (w_wr_gnt),
      .o_idx     (w_wr_idx),
      .o_any     (w_wr_any),
      .o_nxt_ptr (w_wr_nptr)
   );

   rr_pick2 u_rd_pick (
      .i_req     (w_rd_req),
      .i_ptr     (r_rptr),
      .o_gnt     (w_rd_gnt),
      .o_idx     (w_rd_idx),
      .o_any     (w_rd_any),
      .o_nxt_ptr (w_rd_nptr)
   );

   // A read hitting this cycle's write address waits so it sees new data
   assign w_coll  = w_wr_any & w_rd_any &
                    (bus.addr_i[w_wr_idx] == bus.addr_i[w_rd_idx]);
   assign w_wr_ok = w_wr_any & HRESETn;
   assign w_rd_ok = w_rd_any & ~w_coll & HRESETn;

   always_comb begin
      bus.gnt_o     = (w_wr_ok ? w_wr_gnt : '0) |
                      (w_rd_ok ? w_rd_gnt : '0);
      bus.ram_wea   = w_wr_ok ? bus.we_i[w_wr_idx] : '0;
      bus.ram_addra = w_wr_ok ? bus.addr_i[w_wr_idx] : r_addra;
      bus.ram_dina  = w_wr_ok ? bus.wdata_i[w_wr_idx] : r_dina;
      bus.ram_addrb = w_rd_ok ? bus.addr_i[w_rd_idx] : r_addrb;
      bus.rvalid_o  = r_rvld ? idx2oh(r_ridx) : '0;
      bus.rdata_o   = bus.ram_doutb;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_rvld  <= 1'b0;
         r_ridx  <= 1'b0;
         r_addra <= '0;
         r_addrb <= '0;
         r_dina  <= '0;
      end else begin
         r_rvld <= w_rd_ok;
         if (w_wr_ok) begin
            r_wptr  <= w_wr_nptr;
            r_addra <= bus.addr_i[w_wr_idx];
            r_dina  <= bus.wdata_i[w_wr_idx];
         end
         if (w_rd_ok) begin
            r_rptr  <= w_rd_nptr;
            r_ridx  <= w_rd_idx;
            r_addrb <= bus.addr_i[w_rd_idx];
         end
      end
   end

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized and directed bench for bram_arbiter with a RAM model and
// a transaction-level reference model of the arbitration rules.
module tb_bram_arbiter;

   localparam int AW = 14;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   bram_arbiter #(.ADDR_WIDTH(AW)) dut (
      .HCLK    (clk),
      .HRESETn (rst_n),
      .bus     (bus)
   );

   // Block RAM: byte writes, registered read, 128 words used
   logic [31:0] ram [128];
   logic        ram_rdy = 1'b0;

   always @(posedge clk) begin
      if (!ram_rdy) begin
         for (int k = 0; k < 128; k++) ram[k] <= '0;
         ram_rdy <= 1'b1;
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus.ram_wea[b])
               ram[bus.ram_addra[6:0]][8*b +: 8] <= bus.ram_dina[8*b +: 8];
      end
      bus.ram_doutb <= ram[bus.ram_addrb[6:0]];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [31:0] mm [128];
   int          m_wptr = 0;
   int          m_rptr = 0;
   logic [1:0]  m_rv   = '0;
   logic [31:0] m_rdat = '0;

   logic [1:0]  obs_gnt;
   logic [1:0]  obs_rv;
   logic [31:0] obs_rdata;
   logic [3:0]  obs_wea;

   task automatic set_rq(int i, bit r, logic [3:0] w,
                         logic [AW-1:0] a, logic [31:0] d);
      bus.req_i[i]   = r;
      bus.we_i[i]    = w;
      bus.addr_i[i]  = a;
      bus.wdata_i[i] = d;
   endtask

   function automatic int pick(bit r0, bit r1, int ptr);
      if (r0 && r1) return ptr;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   // One clock: check this cycle against the model, then advance it
   task automatic step();
      int          ww, rw;
      bit          w0, w1, q0, q1;
      logic [1:0]  eg;
      logic [31:0] cur, nv;
      @(negedge clk);
      ww = -1;
      rw = -1;
      if (!rst_n) begin
         m_wptr = 0;
         m_rptr = 0;
         m_rv   = '0;
      end else begin
         w0 = bus.req_i[0] && (bus.we_i[0] != 0);
         w1 = bus.req_i[1] && (bus.we_i[1] != 0);
         q0 = bus.req_i[0] && (bus.we_i[0] == 0);
         q1 = bus.req_i[1] && (bus.we_i[1] == 0);
         ww = pick(w0, w1, m_wptr);
         rw = pick(q0, q1, m_rptr);
         if (ww >= 0 && rw >= 0 && bus.addr_i[ww] == bus.addr_i[rw])
            rw = -1;
      end
      eg = '0;
      if (ww >= 0) eg[ww] = 1'b1;
      if (rw >= 0) eg[rw] = 1'b1;
      obs_gnt   = bus.gnt_o;
      obs_rv    = bus.rvalid_o;
      obs_rdata = bus.rdata_o;
      obs_wea   = bus.ram_wea;
      chk("gnt", 32'(obs_gnt), 32'(eg));
      chk("rvalid", 32'(obs_rv), 32'(m_rv));
      if (m_rv != 0) chk("rdata", obs_rdata, m_rdat);
      m_rv = '0;
      if (rw >= 0) begin
         m_rv[rw] = 1'b1;
         m_rdat   = mm[bus.addr_i[rw][6:0]];
         m_rptr   = 1 - rw;
      end
      if (ww >= 0) begin
         cur = mm[bus.addr_i[ww][6:0]];
         nv  = bus.wdata_i[ww];
         for (int b = 0; b < 4; b++)
            if (bus.we_i[ww][b]) cur[8*b +: 8] = nv[8*b +: 8];
         mm[bus.addr_i[ww][6:0]] = cur;
         m_wptr = 1 - ww;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      set_rq(0, 0, 4'h0, '0, '0);
      set_rq(1, 0, 4'h0, '0, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_rq(0, 1, 4'hF, 14'h7, 32'hCAFEF00D);
      set_rq(1, 1, 4'h0, 14'h3, '0);
      step();
      chk("rst_gnt", 32'(obs_gnt), 32'h0);
      chk("rst_wea", 32'(obs_wea), 32'h0);
      chk("rst_rv", 32'(obs_rv), 32'h0);
      idle_all();
      step();
      rst_n = 1'b1;
   endtask

   task automatic new_req(int i);
      logic [3:0] w;
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      set_rq(i, ($urandom_range(0, 3) != 0), w,
             AW'($urandom_range(0, 7)), $urandom);
   endtask

   initial begin
      for (int k = 0; k < 128; k++) mm[k] = '0;
      idle_all();
      do_reset();

      // Single write then read
      set_rq(0, 1, 4'hF, 14'h10, 32'hDEADBEEF);
      step();
      chk("wr_gnt", 32'(obs_gnt), 32'h1);
      set_rq(0, 1, 4'h0, 14'h10, '0);
      step();
      chk("rd_gnt", 32'(obs_gnt), 32'h1);
      idle_all();
      step();
      chk("rd_rv", 32'(obs_rv), 32'h1);
      chk("rd_data", obs_rdata, 32'hDEADBEEF);

      // Byte strobes
      set_rq(0, 1, 4'hF, 14'h20, 32'h11223344);
      step();
      set_rq(0, 1, 4'h5, 14'h20, 32'hAABBCCDD);
      step();
      set_rq(0, 1, 4'h0, 14'h20, '0);
      step();
      idle_all();
      step();
      chk("be_data", obs_rdata, 32'h11BB33DD);

      // Parallel write and read
      set_rq(0, 1, 4'hF, 14'h30, 32'h0BADCAFE);
      set_rq(1, 1, 4'h0, 14'h31, '0);
      step();
      chk("par_gnt", 32'(obs_gnt), 32'h3);
      idle_all();
      step();
      chk("par_rv", 32'(obs_rv), 32'h2);

      // Same-address collision
      set_rq(0, 1, 4'hF, 14'h40, 32'h55);
      set_rq(1, 1, 4'h0, 14'h40, '0);
      step();
      chk("col_gnt0", 32'(obs_gnt), 32'h1);
      set_rq(0, 0, 4'h0, '0, '0);
      step();
      chk("col_gnt1", 32'(obs_gnt), 32'h2);
      idle_all();
      step();
      chk("col_rv", 32'(obs_rv), 32'h2);
      chk("col_data", obs_rdata, 32'h55);

      // Read-port fairness after reset
      do_reset();
      set_rq(0, 1, 4'h0, 14'h50, '0);
      set_rq(1, 1, 4'h0, 14'h51, '0);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("fair_gnt", 32'(obs_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
         if (k > 0)
            chk("fair_rv", 32'(obs_rv), (k % 2 == 1) ? 32'h1 : 32'h2);
      end
      idle_all();
      step();
      chk("fair_rv_last", 32'(obs_rv), 32'h2);

      // Reset during an in-flight read
      set_rq(0, 1, 4'h0, 14'h10, '0);
      step();
      rst_n = 1'b0;
      set_rq(1, 1, 4'h0, 14'h11, '0);
      step();
      chk("mid_rv", 32'(obs_rv), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("mid_rv_rel", 32'(obs_rv), 32'h0);
      chk("mid_gnt", 32'(obs_gnt), 32'h1);
      idle_all();
      step();

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++)
            if (!bus.req_i[i] || obs_gnt[i]) new_req(i);
         step();
      end
      idle_all();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
